piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the 4-bit SIPO shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first onto a single serial line, one bit per clock.
- After WIDTH shifts, the downstream SIPO holds the word in its original bit order.
- Supports back-to-back frames with no idle gap.

Parameters:
- WIDTH, 4, parallel word width in bits (≥2).
- IDLE_LEVEL, 1'b0, serial_out level when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  source presents a word on par_in.
- load_ready  output  1  block can accept a word this cycle (combinational).
- par_in  input  WIDTH  parallel word; sampled only on a handshake.
- serial_out  output  1  serial bit, registered, MSB-first.
- serial_valid  output  1  high while serial_out carries a frame bit.
- frame_start  output  1  one-cycle pulse coincident with the first bit of each frame.
- busy  output  1  high while in SHIFT (or PARITY) state.

Behaviour:
- Reset (asynchronous, on rst high): state=IDLE, shift_reg=0, bit_cnt=0, serial_out=IDLE_LEVEL, serial_valid=0, frame_start=0, busy=0.
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame data bits being driven.
  - PARITY: exists only with the option enabled.
- Handshake: a word is accepted at a rising edge where load_valid && load_ready.
  - load_valid while load_ready=0 is ignored and nothing is captured; the source holds its word.
- load_ready = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1), without the option.
- Accept edge:
  - shift_reg <= par_in; serial_out <= par_in[WIDTH-1]; serial_valid <= 1; frame_start <= 1; bit_cnt <= 0; state <= SHIFT.
  - Latency: first bit is visible in the cycle immediately after the accept edge.
- SHIFT with bit_cnt < WIDTH-1:
  - shift_reg shifts left by 1; serial_out <= shift_reg[WIDTH-2]; bit_cnt++; frame_start <= 0.
- SHIFT with bit_cnt == WIDTH-1 (last bit):
  - If a new word is accepted, apply the accept-edge actions (back-to-back, no gap, frame_start pulses again).
  - Otherwise: state <= IDLE, serial_valid <= 0, serial_out <= IDLE_LEVEL, frame_start <= 0.
- Frame occupancy: exactly WIDTH consecutive serial_valid cycles per frame.
- busy is high for the same cycles as serial_valid.
- Reset mid-frame: the frame is abandoned immediately and outputs go to reset values. No partial frame resumes after release.
- bit_cnt width is $clog2(WIDTH); wrap-around is never reached because the count reloads at WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, state goes to PARITY for one cycle: serial_out = even parity (XOR) of the accepted word, serial_valid=1.
  - Frame length is WIDTH+1.
  - load_ready is asserted during the PARITY cycle instead of the last data bit; back-to-back reload occurs from PARITY.
  - The data-bit load_ready term is removed.
- Undefined: no PARITY state, frame length WIDTH, behaviour as above.

Decomposition:
- Shared package (piso_pkg) holds:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2;
  - default WIDTH;
  - counter-width constant.
- Single module is natural.
- The existing synchronous-reset d_ff is not reused, because reset here is asynchronous.

Test Plan:
- Reset: assert rst for 2 cycles mid-clock → all outputs at reset values immediately, load_ready=1.
- Single frame: par_in=4'b1011, one-cycle load_valid → serial_out 1,0,1,1 over the next 4 cycles; frame_start high in the first cycle only; serial_valid low in the 5th.
- Back-to-back: 4'b1011 then 4'b0110, with load_valid held through the last bit → 8 contiguous valid bits 1,0,1,1,0,1,1,0; two frame_start pulses 4 cycles apart.
- Busy reject: pulse load_valid with 4'b1111 during bit 2 of a 4'b0000 frame → pulse ignored, serial_out stays 0,0,0,0, no new frame.
- Reset mid-frame: rst high during bit 2 of 4'b1011 → serial_out=IDLE_LEVEL and serial_valid=0 asynchronously; after release, the next load starts a clean frame.
- Chained with the SIPO (shared clk; rst released first): send 4'b1011 → on the edge after the 4th bit, SIPO Q=4'b1011.
  - With PISO_PARITY_EN: 5th bit equals 1 (parity of 1011).

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the PISO serializer
//
// Purpose: FSM state encoding, default word width and the bit-counter width
//          helper used by piso_serializer.
// Ports:   none (package).
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } piso_state_e;

   localparam int PISO_DEFAULT_WIDTH = 4;

   // Counter indexes bits 0..width-1; never narrower than one bit.
   function automatic int piso_cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   localparam int PISO_CNT_W = piso_cnt_w(PISO_DEFAULT_WIDTH);

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage, MSB-first
//
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake and drives it
//          one bit per clock onto serial_out, MSB first, with back-to-back
//          frames and no idle gap.
// Option:  define PISO_PARITY_EN to append one even-parity bit per frame.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   load_valid   in   source presents a word on par_in
//   load_ready   out  word can be accepted this cycle (combinational)
//   par_in       in   parallel word, sampled on handshake only
//   serial_out   out  registered serial bit
//   serial_valid out  serial_out carries a frame bit
//   frame_start  out  pulse with the first bit of each frame
//   busy         out  frame in progress
module piso_serializer
   import piso_pkg::*;
#(
   parameter int   WIDTH      = PISO_DEFAULT_WIDTH,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] par_in,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int               CNT_W    = piso_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   piso_state_e      state_q, state_d;
   logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             serial_out_q, serial_out_d;
   logic             serial_valid_q, serial_valid_d;
   logic             frame_start_q, frame_start_d;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic last_bit;
   logic accept;

   assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT);

`ifdef PISO_PARITY_EN
   // Reload moves to the parity cycle so the parity bit is never dropped.
   assign load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
   assign load_ready = (state_q == IDLE) || last_bit;
`endif

   assign accept = load_valid && load_ready;

   always_comb begin
      state_d        = state_q;
      shift_reg_d    = shift_reg_q;
      bit_cnt_d      = bit_cnt_q;
      serial_out_d   = serial_out_q;
      serial_valid_d = serial_valid_q;
      frame_start_d  = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d       = parity_q;
`endif

      case (state_q)
         SHIFT: begin
            if (!last_bit) begin
               // serial_out already shows the MSB; the next bit sits one below.
               shift_reg_d  = shift_reg_q << 1;
               serial_out_d = shift_reg_q[WIDTH-2];
               bit_cnt_d    = bit_cnt_q + 1'b1;
            end else begin
`ifdef PISO_PARITY_EN
               state_d      = PARITY;
               serial_out_d = parity_q;
`else
               state_d        = IDLE;
               serial_valid_d = 1'b0;
               serial_out_d   = IDLE_LEVEL;
`endif
            end
         end
         PARITY: begin
            state_d        = IDLE;
            serial_valid_d = 1'b0;
            serial_out_d   = IDLE_LEVEL;
         end
         default: ;
      endcase

      // A handshake overrides the end-of-frame path, giving gapless frames.
      if (accept) begin
         state_d        = SHIFT;
         shift_reg_d    = par_in;
         serial_out_d   = par_in[WIDTH-1];
         serial_valid_d = 1'b1;
         frame_start_d  = 1'b1;
         bit_cnt_d      = '0;
`ifdef PISO_PARITY_EN
         parity_d       = ^par_in;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         shift_reg_q    <= '0;
         bit_cnt_q      <= '0;
         serial_out_q   <= IDLE_LEVEL;
         serial_valid_q <= 1'b0;
         frame_start_q  <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q       <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         shift_reg_q    <= shift_reg_d;
         bit_cnt_q      <= bit_cnt_d;
         serial_out_q   <= serial_out_d;
         serial_valid_q <= serial_valid_d;
         frame_start_q  <= frame_start_d;
`ifdef PISO_PARITY_EN
         parity_q       <= parity_d;
`endif
      end
   end

   assign serial_out   = serial_out_q;
   assign serial_valid = serial_valid_q;
   assign frame_start  = frame_start_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
module tb_piso_serializer;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = W + 1;
   localparam logic [15:0] B2B_EXP = 16'h02EC;  // 1011 p1 0110 p0
`else
   localparam int FRAME_LEN = W;
   localparam logic [15:0] B2B_EXP = 16'h00B6;  // 1011 0110
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [W-1:0] par_in = '0;
   logic         serial_out;
   logic         serial_valid;
   logic         frame_start;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   // Reference: queue of bits still to appear on the line, with first-bit flags.
   logic exp_bits[$];
   logic exp_start[$];

   logic         seen_out, seen_valid, seen_fs;
   logic [W-1:0] sipo_q;
   logic         acc;

   piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .par_in       (par_in),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .frame_start  (frame_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Downstream 4-bit SIPO, shifting in from the LSB end.
   always @(posedge clk) sipo_q <= {sipo_q[W-2:0], serial_out};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] word);
      for (int i = W - 1; i >= 0; i--) begin
         exp_bits.push_back(word[i]);
         exp_start.push_back(i == W - 1);
      end
`ifdef PISO_PARITY_EN
      exp_bits.push_back(^word);
      exp_start.push_back(1'b0);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out"},   32'(serial_out),   32'd0);
      check({tag, "_valid"}, 32'(serial_valid), 32'd0);
      check({tag, "_fs"},    32'(frame_start),  32'd0);
      check({tag, "_busy"},  32'(busy),         32'd0);
      check({tag, "_ready"}, 32'(load_ready),   32'd1);
   endtask

   // One clock: drive at negedge, check mid-cycle, update model at posedge.
   task automatic cycle(input logic v, input logic [W-1:0] d, output logic accepted);
      logic model_ready;
      load_valid = v;
      par_in     = d;
      #1;
      model_ready = (exp_bits.size() <= 1);
      seen_out    = serial_out;
      seen_valid  = serial_valid;
      seen_fs     = frame_start;
      if (exp_bits.size() == 0) begin
         check("idle_valid", 32'(serial_valid), 32'd0);
         check("idle_out",   32'(serial_out),   32'd0);
         check("idle_fs",    32'(frame_start),  32'd0);
         check("idle_busy",  32'(busy),         32'd0);
      end else begin
         check("bit_valid", 32'(serial_valid), 32'd1);
         check("bit_out",   32'(serial_out),   32'(exp_bits[0]));
         check("bit_fs",    32'(frame_start),  32'(exp_start[0]));
         check("bit_busy",  32'(busy),         32'd1);
      end
      check("load_ready", 32'(load_ready), 32'(model_ready));
      accepted = v && model_ready;
      @(posedge clk);
      if (exp_bits.size() > 0) begin
         void'(exp_bits.pop_front());
         void'(exp_start.pop_front());
      end
      if (accepted) push_frame(d);
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] got;
      int          n;
      int          fs_cnt;
      int          fs_pos[$];
      logic        pend_v;
      logic [W-1:0] pend_d;

      // Reset asserted mid-cycle, before any clock edge: outputs clear at once.
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single frame 1011.
      cycle(1'b1, 4'b1011, acc);
      check("single_accept", 32'(acc), 32'd1);
      got = '0; fs_cnt = 0;
      for (int i = 0; i < W; i++) begin
         cycle(1'b0, 4'b0000, acc);
         got = {got[14:0], seen_out};
         if (seen_fs) fs_cnt++;
      end
      check("single_bits", 32'(got), 32'h000B);
      check("single_fs_count", 32'(fs_cnt), 32'd1);
      check("sipo_q", 32'(sipo_q), 32'h000B);
      cycle(1'b0, 4'b0000, acc);
`ifdef PISO_PARITY_EN
      check("parity_valid", 32'(seen_valid), 32'd1);
      check("parity_bit",   32'(seen_out),   32'd1);
      cycle(1'b0, 4'b0000, acc);
`endif
      check("single_end_valid", 32'(seen_valid), 32'd0);

      // Back-to-back 1011 then 0110, second word held until taken.
      got = '0; n = 0; fs_pos.delete();
      cycle(1'b1, 4'b1011, acc);
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         cycle(1'b1, 4'b0110, acc);
         if (seen_valid) begin
            got = {got[14:0], seen_out};
            if (seen_fs) fs_pos.push_back(n);
            n++;
         end
      end
      check("b2b_accepted", 32'(acc), 32'd1);
      for (int i = 0; i < FRAME_LEN + 2; i++) begin
         cycle(1'b0, 4'b0000, acc);
         if (seen_valid) begin
            got = {got[14:0], seen_out};
            if (seen_fs) fs_pos.push_back(n);
            n++;
         end
      end
      check("b2b_len",  32'(n),   32'(2 * FRAME_LEN));
      check("b2b_bits", 32'(got), 32'(B2B_EXP));
      check("b2b_fs_count", 32'(fs_pos.size()), 32'd2);
      if (fs_pos.size() == 2) begin
         check("b2b_fs0", 32'(fs_pos[0]), 32'd0);
         check("b2b_fs1", 32'(fs_pos[1]), 32'(FRAME_LEN));
      end

      // Busy reject: 1111 pulsed during the third bit of a 0000 frame.
      cycle(1'b1, 4'b0000, acc);
      cycle(1'b0, 4'b0000, acc);
      cycle(1'b0, 4'b0000, acc);
      cycle(1'b1, 4'b1111, acc);
      check("reject_acc", 32'(acc), 32'd0);
      check("reject_bit", 32'(seen_out), 32'd0);
      for (int i = 0; i < FRAME_LEN - 2; i++) cycle(1'b0, 4'b0000, acc);
      check("reject_end_valid", 32'(serial_valid), 32'd0);

      // Reset during the third bit of 1011.
      cycle(1'b1, 4'b1011, acc);
      cycle(1'b0, 4'b0000, acc);
      cycle(1'b0, 4'b0000, acc);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      exp_bits.delete();
      exp_start.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 4'b0110, acc);
      got = '0;
      for (int i = 0; i < W; i++) begin
         cycle(1'b0, 4'b0000, acc);
         got = {got[14:0], seen_out};
      end
      check("post_reset_bits", 32'(got), 32'h0006);
      for (int i = 0; i < FRAME_LEN - W + 1; i++) cycle(1'b0, 4'b0000, acc);

      // Randomized traffic; the source holds each word until it is accepted.
      pend_v = 1'b0;
      pend_d = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pend_v) begin
            pend_v = ($urandom_range(0, 2) != 0);
            pend_d = W'($urandom);
         end
         cycle(pend_v, pend_d, acc);
         if (acc) pend_v = 1'b0;
      end
      for (int i = 0; i < FRAME_LEN + 2; i++) cycle(1'b0, 4'b0000, acc);
      check("drain_empty", 32'(exp_bits.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
